// File: rtl/ifq_pkg.sv
// Shared types and constants for the MCPU fetch queue.
// Entry layout, PC increment and the idle instruction value.
package ifq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {pc, instr} entries.
// Flush empties it in one edge; push/pop may happen together.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  ifq_entry_t    wdata,
    output ifq_entry_t    rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    ifq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem_q[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch PC sequencer and prefetch queue feeding decode.
// Define IFQ_BYPASS_EN for a zero-latency path when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [31:0]              pc_o,
    input  logic [31:0]              instr_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_instr_o,
    output logic [31:0]              out_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic          fetch;
    logic          pop;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    ifq_entry_t    head;
    ifq_entry_t    wr_entry;
    logic          head_valid;
    logic [31:0]   head_instr;
    logic [31:0]   head_pc;

    assign wr_entry = '{pc: fetch_pc, instr: instr_i};

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        head_valid = rst_n && !redirect_i && !fifo_empty;
        head_instr = head.instr;
        head_pc    = head.pc;
`ifdef IFQ_BYPASS_EN
        if (rst_n && !redirect_i && fifo_empty) begin
            head_valid = 1'b1;
            head_instr = instr_i;
            head_pc    = fetch_pc;
        end
`endif
        pop      = head_valid && out_ready_i;
        fetch    = rst_n && !redirect_i && (!fifo_full || pop);
        fifo_pop = pop && !fifo_empty;
        // a bypassed word that decode takes never enters the queue
        fifo_push = fetch && !(pop && fifo_empty);
    end

    assign out_valid_o = head_valid;
    assign out_instr_o = head_valid ? head_instr : NOP_INSTR;
    assign out_pc_o    = head_pc;
    assign pc_o        = rst_n ? fetch_pc : RESET_PC;
    assign count_o     = rst_n ? fifo_count : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= align_pc(redirect_pc_i);
        end else if (fetch) begin
            fetch_pc <= fetch_pc + PC_INC;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect;
    logic        ready;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        valid;
    logic [2:0]  count;

    logic        redirect2;
    logic        ready2;
    logic [31:0] rpc2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic [31:0] out_instr2;
    logic [31:0] out_pc2;
    logic        valid2;
    logic [2:0]  count2;

    int checks = 0;
    int failures = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    assign instr  = mem(pc);
    assign instr2 = mem(pc2);

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc), .instr_i(instr),
        .redirect_i(redirect), .redirect_pc_i(rpc),
        .out_valid_o(valid), .out_ready_i(ready),
        .out_instr_o(out_instr), .out_pc_o(out_pc), .count_o(count)
    );

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .pc_o(pc2), .instr_i(instr2),
        .redirect_i(redirect2), .redirect_pc_i(rpc2),
        .out_valid_o(valid2), .out_ready_i(ready2),
        .out_instr_o(out_instr2), .out_pc_o(out_pc2), .count_o(count2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc = 32'h0;

    task automatic model_check();
        bit          ev;
        logic [31:0] epc;
        ev  = 1'b0;
        epc = 32'h0;
        if (rst_n && !redirect) begin
            if (q.size() > 0) begin
                ev  = 1'b1;
                epc = q[0].pc;
            end
`ifdef IFQ_BYPASS_EN
            else begin
                ev  = 1'b1;
                epc = mpc;
            end
`endif
        end
        chk("rnd_valid", 32'(valid), 32'(ev));
        chk("rnd_count", 32'(count), rst_n ? 32'(q.size()) : 32'h0);
        chk("rnd_pc", pc, rst_n ? mpc : 32'h0);
        if (ev) begin
            chk("rnd_out_pc", out_pc, epc);
            chk("rnd_out_instr", out_instr, mem(epc));
        end
    endtask

    task automatic model_step();
        int sz;
        bit pop;
        bit push;
        if (!rst_n) begin
            q.delete();
            mpc = 32'h0;
        end else if (redirect) begin
            q.delete();
            mpc = rpc & ~32'h3;
        end else begin
            sz = q.size();
`ifdef IFQ_BYPASS_EN
            pop = ready;
`else
            pop = ready && sz > 0;
`endif
            push = (sz < DEPTH) || pop;
            if (pop && sz > 0) void'(q.pop_front());
            if (push && !(pop && sz == 0)) q.push_back('{mpc, mem(mpc)});
            if (push) mpc = mpc + 32'd4;
        end
    endtask

    typedef struct {
        bit          rst_n;
        bit          redirect;
        bit          ready;
        logic [31:0] rpc;
        bit          ev;
        int          ecnt;
        logic [31:0] epc;
        logic [31:0] eopc;
    } vec_t;

    vec_t tbl[20];

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        ready = 1'b1;
        rpc = 32'h0;
        redirect2 = 1'b0;
        ready2 = 1'b1;
        rpc2 = 32'h0;

`ifndef IFQ_BYPASS_EN
        tbl = '{
            '{0, 0, 1, 32'h00, 0, 0, 32'h00, 32'h00},
            '{0, 0, 1, 32'h00, 0, 0, 32'h00, 32'h00},
            '{1, 0, 1, 32'h00, 0, 0, 32'h00, 32'h00},
            '{1, 0, 1, 32'h00, 1, 1, 32'h04, 32'h00},
            '{1, 0, 1, 32'h00, 1, 1, 32'h08, 32'h04},
            '{1, 0, 0, 32'h00, 1, 1, 32'h0C, 32'h08},
            '{1, 0, 0, 32'h00, 1, 2, 32'h10, 32'h08},
            '{1, 1, 1, 32'h43, 0, 3, 32'h14, 32'h00},
            '{1, 0, 1, 32'h00, 0, 0, 32'h40, 32'h00},
            '{1, 0, 1, 32'h00, 1, 1, 32'h44, 32'h40},
            '{1, 0, 0, 32'h00, 1, 1, 32'h48, 32'h44},
            '{1, 0, 0, 32'h00, 1, 2, 32'h4C, 32'h44},
            '{1, 0, 0, 32'h00, 1, 3, 32'h50, 32'h44},
            '{1, 0, 0, 32'h00, 1, 4, 32'h54, 32'h44},
            '{1, 0, 0, 32'h00, 1, 4, 32'h54, 32'h44},
            '{1, 0, 1, 32'h00, 1, 4, 32'h54, 32'h44},
            '{1, 0, 1, 32'h00, 1, 4, 32'h58, 32'h48},
            '{1, 0, 1, 32'h00, 1, 4, 32'h5C, 32'h4C},
            '{0, 0, 1, 32'h00, 0, 0, 32'h00, 32'h00},
            '{1, 0, 1, 32'h00, 0, 0, 32'h00, 32'h00}
        };

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst_n    = tbl[i].rst_n;
            redirect = tbl[i].redirect;
            ready    = tbl[i].ready;
            rpc      = tbl[i].rpc;
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].epc);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].eopc);
                chk($sformatf("tbl%0d_out_instr", i), out_instr,
                    mem(tbl[i].eopc));
            end
        end

        // PC wrap from the top of the address space
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b1;
        redirect = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("wrap_pc_reset", pc2, 32'hFFFF_FFFC);
        chk("wrap_count_reset", 32'(count2), 32'h0);
        @(negedge clk);
        #1;
        chk("wrap_valid", 32'(valid2), 32'h1);
        chk("wrap_out_pc0", out_pc2, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc2, 32'h0);
        @(negedge clk);
        #1;
        chk("wrap_out_pc1", out_pc2, 32'h0);
        chk("wrap_out_instr1", out_instr2, mem(32'h0));
`else
        @(negedge clk);
        rst_n = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk($sformatf("byp%0d_valid", i), 32'(valid), 32'h1);
            chk($sformatf("byp%0d_out_pc", i), out_pc, 32'(i * 4));
            chk($sformatf("byp%0d_count", i), 32'(count), 32'h0);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n    = (i == 0) ? 1'b0 : ($urandom_range(99) >= 2);
            redirect = ($urandom_range(99) < 8);
            rpc      = $urandom;
            ready    = ($urandom_range(99) < 60);
            #1;
            model_check();
            @(posedge clk);
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
